// File: rtl/alu_pipe_n.sv
// alu_pipe_n: WIDTH-bit 16-opcode ALU with a valid/ready handshake.
// Results land in a single output register stage (1-cycle latency).
// An internal accumulator can stand in for operand A.
// Ops 1-4 support optional signed or unsigned saturation.
module alu_pipe_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       OpCode,
    input  logic             use_acc,
    input  logic             acc_clear,
    input  logic             sat,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             OF,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             out_oe
);

    localparam int               M        = WIDTH - 1;
    localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp an ops-1..4 result. On signed overflow the wrapped sign is the
    // opposite of the true sign, so a negative wrapped value means the
    // true result was positive. The clamp direction for unsigned carry
    // depends on whether the op counts up (1-2) or down (3-4).
    function automatic logic [WIDTH-1:0] f_saturate(
        input logic [WIDTH-1:0] res,
        input logic             ovf,
        input logic             cy,
        input logic             sgn,
        input logic             up
    );
        logic [WIDTH-1:0] v;
        v = res;
        if (sgn) begin
            if (ovf) v = res[M] ? SMAX : SMIN;
        end else if (cy) begin
            v = up ? ALL_ONES : '0;
        end
        return v;
    endfunction

    logic                    r_vld_p1;
    logic [WIDTH-1:0]        r_alu_p1;
    logic                    r_of_p1;
    logic                    r_cy_p1;
    logic                    r_zero_p1;
    logic                    r_neg_p1;
    logic                    r_oe_p1;
    logic [WIDTH-1:0]        r_acc;

    logic                    w_accept;
    logic [WIDTH-1:0]        w_acc_eff;
    logic [WIDTH-1:0]        w_opa;
    logic signed [WIDTH-1:0] w_opa_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH-1:0]        w_res_p0;
    logic [WIDTH-1:0]        w_final_p0;
    logic                    w_of_p0;
    logic                    w_cy_p0;
    logic                    w_oe_p0;
    logic                    w_arith;
    logic                    w_up;
    logic                    w_zero_p0;
    logic                    w_neg_p0;

    assign in_ready  = !rst && (!r_vld_p1 || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_acc_eff = acc_clear ? '0 : r_acc;
    assign w_opa     = use_acc ? w_acc_eff : a;
    assign w_opa_s   = w_opa;
    assign w_b_s     = b;

    // Stage p0: combinational opcode decode, raw result and pre-clamp flags
    always_comb begin
        w_sum    = '0;
        w_res_p0 = '0;
        w_of_p0  = 1'b0;
        w_cy_p0  = 1'b0;
        w_oe_p0  = 1'b1;
        w_arith  = 1'b0;
        w_up     = 1'b0;
        case (OpCode)
            4'h0: w_res_p0 = w_opa;
            4'h1: begin
                w_sum    = {1'b0, w_opa} + ONE_X;
                w_res_p0 = w_sum[M:0];
                w_cy_p0  = w_sum[WIDTH];
                w_of_p0  = ~w_opa[M] & w_res_p0[M];
                w_arith  = 1'b1;
                w_up     = 1'b1;
            end
            4'h2: begin
                w_sum    = {1'b0, w_opa} + {1'b0, b};
                w_res_p0 = w_sum[M:0];
                w_cy_p0  = w_sum[WIDTH];
                w_of_p0  = (w_opa[M] ~^ b[M]) & (w_res_p0[M] ^ w_opa[M]);
                w_arith  = 1'b1;
                w_up     = 1'b1;
            end
            4'h3: begin
                w_sum    = {1'b0, w_opa} - {1'b0, b};
                w_res_p0 = w_sum[M:0];
                w_cy_p0  = w_sum[WIDTH];
                w_of_p0  = (w_opa[M] ^ b[M]) & (w_res_p0[M] ^ w_opa[M]);
                w_arith  = 1'b1;
            end
            4'h4: begin
                w_sum    = {1'b0, w_opa} - ONE_X;
                w_res_p0 = w_sum[M:0];
                w_cy_p0  = w_sum[WIDTH];
                w_of_p0  = w_opa[M] & ~w_res_p0[M];
                w_arith  = 1'b1;
            end
            4'h5: w_res_p0 = ~w_opa;
            4'h6: w_res_p0 = w_opa & b;
            4'h7: w_res_p0 = ~(w_opa & b);
            4'h8: w_res_p0 = w_opa | b;
            4'h9: w_res_p0 = ~(w_opa | b);
            4'hA: w_res_p0 = w_opa ^ b;
            4'hB: w_res_p0 = ~(w_opa ^ b);
            4'hC: w_res_p0 = {{(WIDTH-1){1'b0}},
                              signed_mode ? (w_opa_s > w_b_s) : (w_opa > b)};
            4'hD: w_res_p0 = {{(WIDTH-1){1'b0}},
                              signed_mode ? (w_opa_s < w_b_s) : (w_opa < b)};
            4'hE: w_res_p0 = {{(WIDTH-1){1'b0}}, (w_opa == b)};
            default: w_oe_p0 = 1'b0;
        endcase
    end

    // Saturation and result-derived flags (zero is forced low for opcode F)
    always_comb begin
        w_final_p0 = w_res_p0;
        if (sat && w_arith)
            w_final_p0 = f_saturate(w_res_p0, w_of_p0, w_cy_p0, signed_mode, w_up);
        w_zero_p0 = w_oe_p0 && (w_final_p0 == '0);
        w_neg_p0  = w_final_p0[M];
    end

    // Stage p1: output register, loads on accept, drops valid on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_alu_p1  <= '0;
            r_of_p1   <= 1'b0;
            r_cy_p1   <= 1'b0;
            r_zero_p1 <= 1'b0;
            r_neg_p1  <= 1'b0;
            r_oe_p1   <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_alu_p1  <= w_final_p0;
            r_of_p1   <= w_of_p0;
            r_cy_p1   <= w_cy_p0;
            r_zero_p1 <= w_zero_p0;
            r_neg_p1  <= w_neg_p0;
            r_oe_p1   <= w_oe_p0;
        end else if (out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    // Accumulator: tracks the last result, opcode F only applies acc_clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_oe_p0 ? w_final_p0 : w_acc_eff;
        end else if (acc_clear) begin
            r_acc <= '0;
        end
    end

    assign out_valid = r_vld_p1;
    assign ALUout    = r_alu_p1;
    assign OF        = r_of_p1;
    assign carry     = r_cy_p1;
    assign zero      = r_zero_p1;
    assign neg       = r_neg_p1;
    assign out_oe    = r_oe_p1;

endmodule

// File: tb/tb_alu_pipe_n.sv
// Directed testbench for alu_pipe_n (WIDTH=8) with hand-computed expectations.
module tb_alu_pipe_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] OpCode;
    logic       use_acc;
    logic       acc_clear;
    logic       sat;
    logic       signed_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALUout;
    logic       OF;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       out_oe;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe_n #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .OpCode(OpCode), .use_acc(use_acc), .acc_clear(acc_clear),
        .sat(sat), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .ALUout(ALUout), .OF(OF), .carry(carry),
        .zero(zero), .neg(neg), .out_oe(out_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for exactly one edge, then withdraw it.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] op,
                         input bit ua, input bit ac, input bit s, input bit sm);
        a = ia; b = ib; OpCode = op; use_acc = ua; acc_clear = ac;
        sat = s; signed_mode = sm; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; use_acc = 1'b0; acc_clear = 1'b0;
    endtask

    // Result, valid and flags {OF,carry,zero,neg,oe} in one go.
    task automatic expect_res(input string tag, input logic [7:0] r, input logic [4:0] fl);
        check({tag, ".vld"}, out_valid, 1'b1);
        check({tag, ".res"}, ALUout, r);
        check({tag, ".flg"}, {OF, carry, zero, neg, out_oe}, fl);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; OpCode = '0; use_acc = 1'b0;
        acc_clear = 1'b0; sat = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst.vld", out_valid, 1'b0);
        check("rst.rdy", in_ready, 1'b0);
        check("rst.res", ALUout, 8'h00);
        check("rst.flg", {OF, carry, zero, neg, out_oe}, 5'b00000);
        rst = 1'b0;
        #1;
        check("rst.rdy_after", in_ready, 1'b1);

        // basic subtract, 1-cycle latency
        issue(8'h07, 8'h03, 4'h3, 0, 0, 0, 0);
        expect_res("sub", 8'h04, 5'b00001);

        // arithmetic boundaries
        issue(8'h7F, 8'h01, 4'h2, 0, 0, 0, 0);
        expect_res("add_of", 8'h80, 5'b10011);
        issue(8'h7F, 8'h01, 4'h2, 0, 0, 1, 1);
        expect_res("add_ssat", 8'h7F, 5'b10001);
        issue(8'hFF, 8'h02, 4'h2, 0, 0, 1, 0);
        expect_res("add_usat", 8'hFF, 5'b01011);
        issue(8'h00, 8'h00, 4'h4, 0, 0, 0, 0);
        expect_res("dec_wrap", 8'hFF, 5'b01011);
        issue(8'h80, 8'h01, 4'h3, 0, 0, 1, 1);
        expect_res("sub_ssat", 8'h80, 5'b10011);
        issue(8'h02, 8'h05, 4'h3, 0, 0, 1, 0);
        expect_res("sub_usat", 8'h00, 5'b01101);

        // accumulator chain, back-to-back
        issue(8'h23, 8'h00, 4'h0, 0, 0, 0, 0);
        expect_res("acc0", 8'h23, 5'b00001);
        issue(8'h99, 8'h00, 4'h1, 1, 0, 0, 0);
        expect_res("acc1", 8'h24, 5'b00001);
        issue(8'h99, 8'h10, 4'h2, 1, 0, 0, 0);
        expect_res("acc2", 8'h34, 5'b00001);
        issue(8'h99, 8'h00, 4'h1, 1, 1, 0, 0);
        expect_res("acc3", 8'h01, 5'b00001);

        // backpressure
        issue(8'h07, 8'h03, 4'h3, 0, 0, 0, 0);
        out_ready = 1'b0;
        a = 8'h10; b = 8'h01; OpCode = 4'h2; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.rdy", in_ready, 1'b0);
            check("bp.vld", out_valid, 1'b1);
            check("bp.res", ALUout, 8'h04);
        end
        out_ready = 1'b1;
        #1;
        check("bp.rdy_up", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_res("bp.new", 8'h11, 5'b00001);
        tick();
        check("bp.drain_vld", out_valid, 1'b0);
        check("bp.drain_res", ALUout, 8'h11);

        // compares
        issue(8'h16, 8'hCE, 4'hD, 0, 0, 0, 0);
        expect_res("lt_u", 8'h01, 5'b00001);
        issue(8'h16, 8'hCE, 4'hD, 0, 0, 0, 1);
        expect_res("lt_s", 8'h00, 5'b00101);
        issue(8'hFE, 8'hFE, 4'hE, 0, 0, 0, 0);
        expect_res("eq", 8'h01, 5'b00001);
        issue(8'h14, 8'h05, 4'hC, 0, 0, 0, 0);
        expect_res("gt_u", 8'h01, 5'b00001);
        issue(8'h80, 8'h01, 4'hC, 0, 0, 0, 1);
        expect_res("gt_s", 8'h00, 5'b00101);

        // logic ops
        issue(8'hC3, 8'hAA, 4'h7, 0, 0, 0, 0);
        expect_res("nand", 8'h7D, 5'b00001);
        issue(8'hC3, 8'hAA, 4'hB, 0, 0, 0, 0);
        expect_res("xnor", 8'h96, 5'b00011);

        // opcode F keeps acc
        issue(8'h40, 8'h00, 4'h0, 0, 0, 0, 0);
        expect_res("preF", 8'h40, 5'b00001);
        issue(8'hE5, 8'h56, 4'hF, 0, 0, 0, 0);
        expect_res("opF", 8'h00, 5'b00000);
        issue(8'h00, 8'h00, 4'h0, 1, 0, 0, 0);
        expect_res("postF", 8'h40, 5'b00001);

        // acc_clear without accept
        issue(8'h33, 8'h00, 4'h0, 0, 0, 0, 0);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        issue(8'h77, 8'h00, 4'h0, 1, 0, 0, 0);
        expect_res("idle_clr", 8'h00, 5'b00101);

        // reset while stalled
        issue(8'h55, 8'h00, 4'h0, 0, 0, 0, 0);
        out_ready = 1'b0;
        tick();
        check("pre_rst.vld", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst.vld", out_valid, 1'b0);
        check("mid_rst.res", ALUout, 8'h00);
        rst = 1'b0;
        out_ready = 1'b1;
        issue(8'h66, 8'h00, 4'h0, 1, 0, 0, 0);
        expect_res("acc_rst", 8'h00, 5'b00101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe_n.md
Name: alu_pipe_n

Overview:
Parametrised, registered successor to the team's 8-bit 16-opcode ALU. It keeps the same opcode map and adds several features:
- valid/ready handshake on input and output, with one output register stage;
- an internal accumulator that can replace operand A;
- saturating arithmetic and signed/unsigned compare modes;
- a full flag set (OF, carry, zero, neg).

It sits between an instruction sequencer and a result bus. The opcode-F "no drive" case is signalled by out_oe instead of tristating the output.

Parameters:
WIDTH, 8, datapath width in bits (minimum 2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A (ignored when use_acc=1)
b  in  WIDTH  operand B
OpCode  in  4  operation select
use_acc  in  1  1: operand A = accumulator
acc_clear  in  1  clear accumulator
sat  in  1  1: saturate ops 1-4
signed_mode  in  1  1: two's-complement compare and saturation
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer accepts the result
ALUout  out  WIDTH  registered result
OF  out  1  signed overflow flag
carry  out  1  unsigned carry-out / borrow flag
zero  out  1  ALUout == 0
neg  out  1  ALUout[WIDTH-1]
out_oe  out  1  0 when result is "no drive" (opcode F)

Behaviour:
- Reset: out_valid, ALUout, OF, carry, zero, neg, out_oe and acc all go to 0. in_ready=0 while rst=1. Reset mid-operation discards any held result.
- in_ready = !rst && (!out_valid || out_ready), combinational.
- Accept: in_valid && in_ready at a rising edge.
- On accept, the result is computed combinationally from the current inputs and acc, and loaded into the output register the same edge. out_valid=1 from the next cycle, so latency is 1 cycle.
- Back-to-back accepts give 1 op/cycle.
- If out_valid && !out_ready, all outputs hold stable. No accept occurs while stalled.
- If out_ready=1 with no accept, out_valid drops to 0; ALUout and flags keep their last value.
- Operand A = use_acc ? acc_eff : a, where acc_eff = acc_clear ? 0 : acc.
- Opcode map (A, B are WIDTH-bit operands):
  - 0: A
  - 1: A+1
  - 2: A+B
  - 3: A-B
  - 4: A-1
  - 5: ~A
  - 6: A&B
  - 7: ~(A&B)
  - 8: A|B
  - 9: ~(A|B)
  - A: A^B
  - B: ~(A^B)
  - C: A>B
  - D: A<B
  - E: A==B
  - F: no drive
- Compare ops C-E return 1 in the LSB, zeros elsewhere.
- C and D compare as two's complement when signed_mode=1, otherwise unsigned. E ignores signed_mode.
- Opcode F: ALUout=0, out_oe=0, all flags 0, acc unchanged, out_valid still asserted (handshake completes). All other opcodes set out_oe=1.
- carry: carry-out of bit WIDTH-1 for ops 1 and 2; borrow (A<B unsigned, or A==0 for op 4) for ops 3 and 4; 0 for all other ops.
- OF: two's-complement overflow for ops 1-4; 0 for all other ops.
- Saturation (sat=1, ops 1-4 only):
  - signed_mode=1: on OF, clamp to signed max (0x7F..) if the true result is positive, else signed min (0x80..).
  - signed_mode=0: on carry, clamp to all-ones for ops 1-2, or 0 for ops 3-4.
  - OF and carry report the pre-clamp condition.
- zero and neg are computed from the final (post-saturation) ALUout.
- Accumulator update:
  - On accept with opcode 0-E: acc <= final ALUout value.
  - On accept with opcode F: acc <= acc_eff.
  - acc_clear with no accept: acc <= 0.
  - acc is not directly observable.
- rst has priority over everything else; acc_clear has priority over the stored acc value.

Test Plan:
1. Reset, then a=0x07, b=0x03, OpCode=3, out_ready=1 -> next cycle out_valid=1, ALUout=0x04, carry=0, OF=0, zero=0, out_oe=1.
2. Arithmetic boundaries:
   - a=0x7F, b=0x01, OpCode=2, sat=0 -> ALUout=0x80, OF=1, neg=1.
   - Same with sat=1, signed_mode=1 -> 0x7F, OF=1.
   - a=0xFF, b=0x02, sat=1, signed_mode=0 -> 0xFF, carry=1.
   - a=0x00, OpCode=4, sat=0 -> 0xFF, carry=1.
3. Accumulator chain, back-to-back accepts:
   - OpCode=0, a=0x23 -> 0x23.
   - Then use_acc=1, OpCode=1 -> 0x24.
   - Then use_acc=1, OpCode=2, b=0x10 -> 0x34.
   - Then acc_clear=1, use_acc=1, OpCode=1 -> 0x01.
4. Backpressure: result 0x04 held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, ALUout stays 0x04. Raise out_ready -> new op accepted that edge, its result appears next cycle, no result lost or duplicated.
5. Compares:
   - a=0x16, b=0xCE, OpCode=D, signed_mode=0 -> 0x01; signed_mode=1 -> 0x00.
   - a=b=0xFE, OpCode=E -> 0x01.
   - a=0x14, b=0x05, OpCode=C -> 0x01.
6. Opcode F and reset:
   - a=0xE5, b=0x56, OpCode=F -> out_valid=1, out_oe=0, ALUout=0x00, flags 0; a following use_acc op still sees the prior acc.
   - Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ALUout=0, acc=0.
